// File: rtl/gpio_bus_arbiter_if.sv
// Bundle of signals between the GPIO bus arbiter, its requesters and the GPIO register port.
// The "slave" modport is the arbiter's view. The "master" modport is the surrounding system:
// the requesters plus the peripheral's read-data return.
interface gpio_bus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_wr;
    logic [32*NUM_REQ-1:0] req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ack;
    logic [31:0]           req_rdata;
    logic                  p_cs;
    logic                  p_wr;
    logic [31:0]           p_addr;
    logic [31:0]           p_wdata;
    logic [31:0]           p_rdata;
    logic                  busy;
    logic [1:0]            grant_id;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, p_rdata,
        output req_ack, req_rdata, p_cs, p_wr, p_addr, p_wdata, busy, grant_id
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, p_rdata,
        input  req_ack, req_rdata, p_cs, p_wr, p_addr, p_wdata, busy, grant_id
    );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// GPIO bus arbiter: serialises NUM_REQ (2..4) requesters onto the single GPIO register port.
// One peripheral access per grant (IDLE -> ACCESS -> RESP), read data registered with the ack.
// Selection is round-robin by default; define GPIO_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins).
module gpio_bus_arbiter #(
    parameter int NUM_REQ = 2
) (
    input logic               clk,
    input logic               reset,
    gpio_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t               state;
    logic                 found;
    logic [1:0]           grant_sel;
    logic                 sel_wr;
    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic [NUM_REQ-1:0]   ack_onehot;

    logic [NUM_REQ-1:0]   req_ack;
    logic [31:0]          req_rdata;
    logic                 p_cs;
    logic                 p_wr;
    logic [31:0]          p_addr;
    logic [31:0]          p_wdata;
    logic                 busy;
    logic [1:0]           grant_id;

`ifdef GPIO_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-index active requester wins.
    always_comb begin
        found     = |bus.req_valid;
        grant_sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) grant_sel = 2'(i);
        end
    end
`else
    logic [1:0] last_grant;
    logic       hi_found;
    logic [1:0] hi_sel;
    logic       lo_found;
    logic [1:0] lo_sel;

    // Remember the last winner; reset value makes requester 0 win the first contest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 2'(NUM_REQ - 1);
        end else if (state == StIdle && found) begin
            last_grant <= grant_sel;
        end
    end

    // Round-robin: first active index above last_grant, else wrap to the lowest active index.
    always_comb begin
        hi_found = 1'b0;
        hi_sel   = '0;
        lo_found = 1'b0;
        lo_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && i > int'(last_grant) && !hi_found) begin
                hi_found = 1'b1;
                hi_sel   = 2'(i);
            end
            if (bus.req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_sel   = 2'(i);
            end
        end
        found     = hi_found | lo_found;
        grant_sel = hi_found ? hi_sel : lo_sel;
    end
`endif

    // Route the selected requester's command fields.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_sel == 2'(i)) begin
                sel_wr    = bus.req_wr[i];
                sel_addr  = bus.req_addr[32*i +: 32];
                sel_wdata = bus.req_wdata[32*i +: 32];
            end
        end
    end

    // One-hot ack for the requester currently holding the grant.
    always_comb begin
        ack_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_onehot[i] = (grant_id == 2'(i));
        end
    end

    // Access FSM with registered outputs; p_addr/p_wdata hold their values while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            req_ack   <= '0;
            req_rdata <= '0;
            p_cs      <= 1'b0;
            p_wr      <= 1'b0;
            p_addr    <= '0;
            p_wdata   <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (found) begin
                        p_wr     <= sel_wr;
                        p_addr   <= sel_addr;
                        p_wdata  <= sel_wdata;
                        p_cs     <= 1'b1;
                        grant_id <= grant_sel;
                        busy     <= 1'b1;
                        state    <= StAccess;
                    end
                end
                StAccess: begin
                    // Same edge that commits a write, so a write returns the old value.
                    req_rdata <= bus.p_rdata;
                    req_ack   <= ack_onehot;
                    p_cs      <= 1'b0;
                    p_wr      <= 1'b0;
                    state     <= StResp;
                end
                StResp: begin
                    req_ack <= '0;
                    busy    <= 1'b0;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.req_ack   = req_ack;
    assign bus.req_rdata = req_rdata;
    assign bus.p_cs      = p_cs;
    assign bus.p_wr      = p_wr;
    assign bus.p_addr    = p_addr;
    assign bus.p_wdata   = p_wdata;
    assign bus.busy      = busy;
    assign bus.grant_id  = grant_id;
endmodule
